// File: rtl/cdb_arbiter_pkg.sv
// Shared completion-bus types and default sizing for the CDB arbiter.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_FU    = 4;
  localparam int CDB_BUF_DEPTH = 2;

  // Completion packet produced by an FU tail stage, result already stamped.
  typedef struct packed {
    logic [5:0]  rob_idx;
    logic [4:0]  dest_reg;
    logic [31:0] result;
  } EX_COMPLETE_ENTRY;

endpackage

// File: rtl/cdb_fu_fifo.sv
// Per-FU completion holding FIFO. Pointers wrap naturally; count carries
// one extra bit so that "full" is distinguishable from "empty".
module cdb_fu_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  EX_COMPLETE_ENTRY din,
  output EX_COMPLETE_ENTRY dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  EX_COMPLETE_ENTRY mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only taken when the head leaves this cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; no reset needed, validity is tracked by count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; flush empties just like reset.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers FU completions in per-FU FIFOs and
// broadcasts one per cycle, round-robin across FUs.
// Optional feature: define CDB_BYPASS_EN to let a completion arriving at an
// empty, granted FU pass straight to the bus in the same cycle (bus outputs
// then become combinational). Default build registers all bus outputs.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int NUM_FU    = CDB_NUM_FU,
  parameter  int BUF_DEPTH = CDB_BUF_DEPTH,
  localparam int IDX_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int CNT_W     = $clog2(BUF_DEPTH) + 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               flush,
  input  logic             [NUM_FU-1:0]      fu_done,
  input  EX_COMPLETE_ENTRY [NUM_FU-1:0]      fu_meta,
  output logic             [NUM_FU-1:0]      fu_full,
  output logic                               cdb_valid,
  output EX_COMPLETE_ENTRY                   cdb_entry,
  output logic             [IDX_W-1:0]       cdb_fu_idx,
  output logic                               overflow
);

  EX_COMPLETE_ENTRY [NUM_FU-1:0]            head;
  logic             [NUM_FU-1:0][CNT_W-1:0] count;
  logic             [NUM_FU-1:0]            empty, fifo_full, req, push, pop, drop, byp;
  logic             [IDX_W-1:0]             rr_ptr, grant_idx, next_ptr;
  logic                                     grant_any;
  EX_COMPLETE_ENTRY                         sel_entry, entry_q;
  logic             [IDX_W-1:0]             idx_q;
  logic                                     valid_q;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    cdb_fu_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (fu_meta[i]),
      .dout  (head[i]),
      .count (count[i]),
      .full  (fifo_full[i]),
      .empty (empty[i])
    );
    assign fu_full[i] = (count[i] == CNT_W'(BUF_DEPTH));
  end

`ifdef CDB_BYPASS_EN
  // A fresh completion counts as pending even before it is stored.
  assign req       = ~empty | fu_done;
  assign sel_entry = byp[grant_idx] ? fu_meta[grant_idx] : head[grant_idx];
`else
  assign req       = ~empty;
  assign sel_entry = head[grant_idx];
`endif

  // Round-robin search from rr_ptr upward; lowest offset wins, so scan backwards.
  always_comb begin
    logic [IDX_W:0] cand;
    grant_any = 1'b0;
    grant_idx = rr_ptr;
    cand      = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(NUM_FU)) cand = cand - (IDX_W + 1)'(NUM_FU);
      if (req[cand[IDX_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
    next_ptr = (grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : grant_idx + IDX_W'(1);
  end

  // Per-FU push/pop steering; everything in a flush cycle is dropped.
  always_comb begin
    pop  = '0;
    push = '0;
    drop = '0;
    byp  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
`ifdef CDB_BYPASS_EN
      byp[i]  = grant_any && (grant_idx == IDX_W'(i)) && empty[i] && !flush;
`endif
      pop[i]  = grant_any && (grant_idx == IDX_W'(i)) && !empty[i] && !flush;
      push[i] = fu_done[i] && !flush && !byp[i];
      drop[i] = push[i] && fifo_full[i] && !pop[i];
    end
  end

  // Grant pointer, broadcast register and sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr   <= '0;
      valid_q  <= 1'b0;
      entry_q  <= '0;
      idx_q    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= overflow | (|drop);
      valid_q  <= grant_any & ~flush;
      if (grant_any && !flush) begin
        rr_ptr  <= next_ptr;
        entry_q <= sel_entry;
        idx_q   <= grant_idx;
      end
    end
  end

`ifdef CDB_BYPASS_EN
  assign cdb_valid  = grant_any & ~flush & ~reset;
  assign cdb_entry  = reset ? '0 : (cdb_valid ? sel_entry : entry_q);
  assign cdb_fu_idx = reset ? '0 : (cdb_valid ? grant_idx : idx_q);
`else
  assign cdb_valid  = valid_q;
  assign cdb_entry  = entry_q;
  assign cdb_fu_idx = idx_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = CDB_NUM_FU;
  localparam int D  = CDB_BUF_DEPTH;
  localparam int IW = $clog2(N);

  logic                    clock = 1'b0;
  logic                    reset, flush;
  logic             [N-1:0] fu_done;
  EX_COMPLETE_ENTRY [N-1:0] fu_meta;
  logic             [N-1:0] fu_full;
  logic                     cdb_valid;
  EX_COMPLETE_ENTRY         cdb_entry;
  logic             [IW-1:0] cdb_fu_idx;
  logic                     overflow;

  int n_chk = 0, n_pass = 0;

  // Reference model state
  EX_COMPLETE_ENTRY mq [N][$];
  int               rr, ei;
  logic             ev, eovf;
  EX_COMPLETE_ENTRY ee;
  logic [N-1:0]     efull;

  cdb_arbiter #(.NUM_FU(N), .BUF_DEPTH(D)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .fu_done    (fu_done),
    .fu_meta    (fu_meta),
    .fu_full    (fu_full),
    .cdb_valid  (cdb_valid),
    .cdb_entry  (cdb_entry),
    .cdb_fu_idx (cdb_fu_idx),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  // Model of one clock edge: grant from pre-edge queues, then accept pushes.
  task automatic model_step();
    int g;
    if (reset) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      rr = 0; ev = 1'b0; ee = '0; ei = 0; eovf = 1'b0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      ev = 1'b0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && mq[(rr + k) % N].size() > 0) g = (rr + k) % N;
      ev = (g >= 0);
      if (g >= 0) begin
        ee = mq[g].pop_front();
        ei = g;
        rr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (fu_done[i]) begin
          if (mq[i].size() < D) mq[i].push_back(fu_meta[i]);
          else eovf = 1'b1;
        end
    end
    for (int i = 0; i < N; i++) efull[i] = (mq[i].size() == D);
  endtask

  task automatic rand_meta();
    for (int i = 0; i < N; i++) begin
      fu_meta[i].rob_idx  = 6'($urandom);
      fu_meta[i].dest_reg = 5'($urandom);
      fu_meta[i].result   = $urandom;
    end
  endtask

  task automatic cycle(input logic [N-1:0] d, input logic fl, input logic rst);
    fu_done = d; flush = fl; reset = rst;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    fu_meta = '0;
    cycle('0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b1);
    n_chk++; if (cdb_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", cdb_valid); else n_pass++;
    n_chk++; if (cdb_fu_idx !== '0) $display("FAIL reset_idx got=%0d exp=0", cdb_fu_idx); else n_pass++;
    n_chk++; if (cdb_entry !== '0) $display("FAIL reset_entry got=%h exp=0", cdb_entry); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else n_pass++;
    n_chk++; if (fu_full !== '0) $display("FAIL reset_full got=%b exp=0", fu_full); else n_pass++;
  endtask

  task automatic test_single_op();
    fu_meta = '0;
    fu_meta[2].rob_idx = 6'd5;
    fu_meta[2].result  = 32'h1234_5678;
    cycle(4'b0100, 1'b0, 1'b0);
    n_chk++; if (cdb_valid !== 1'b0) $display("FAIL single_early got=%b exp=0", cdb_valid); else n_pass++;
    cycle('0, 1'b0, 1'b0);
    n_chk++; if (cdb_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", cdb_valid); else n_pass++;
    n_chk++; if (cdb_fu_idx !== 2'd2) $display("FAIL single_idx got=%0d exp=2", cdb_fu_idx); else n_pass++;
    n_chk++; if (cdb_entry.rob_idx !== 6'd5) $display("FAIL single_rob got=%0d exp=5", cdb_entry.rob_idx); else n_pass++;
    n_chk++; if (cdb_entry.result !== 32'h1234_5678) $display("FAIL single_result got=%h exp=12345678", cdb_entry.result); else n_pass++;
    cycle('0, 1'b0, 1'b0);
    n_chk++; if (cdb_valid !== 1'b0) $display("FAIL single_idle got=%b exp=0", cdb_valid); else n_pass++;
    n_chk++; if (cdb_entry.rob_idx !== 6'd5) $display("FAIL single_hold got=%0d exp=5", cdb_entry.rob_idx); else n_pass++;
  endtask

  task automatic test_contention();
    cycle('0, 1'b0, 1'b1);
    fu_meta = '0;
    for (int i = 0; i < N; i++) fu_meta[i].rob_idx = 6'(10 + i);
    cycle(4'b1111, 1'b0, 1'b0);
    for (int k = 0; k < N; k++) begin
      cycle('0, 1'b0, 1'b0);
      n_chk++; if (cdb_valid !== 1'b1 || cdb_fu_idx !== IW'(k) || cdb_entry.rob_idx !== 6'(10 + k))
        $display("FAIL contention_order k=%0d got v=%b idx=%0d rob=%0d exp v=1 idx=%0d rob=%0d",
                 k, cdb_valid, cdb_fu_idx, cdb_entry.rob_idx, k, 10 + k);
      else n_pass++;
    end
    // rr_ptr back at 0: FU0 must beat FU3 when both arrive together.
    cycle(4'b1001, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    n_chk++; if (cdb_fu_idx !== 2'd0) $display("FAIL contention_wrap got=%0d exp=0", cdb_fu_idx); else n_pass++;
    cycle('0, 1'b0, 1'b0);
    n_chk++; if (cdb_fu_idx !== 2'd3) $display("FAIL contention_wrap2 got=%0d exp=3", cdb_fu_idx); else n_pass++;
  endtask

  task automatic test_fill();
    // Keep FUs 2,3,0 busy so FU1 is passed over while it fills.
    fu_meta = '0;
    fu_meta[0].rob_idx = 6'd20; fu_meta[2].rob_idx = 6'd21; fu_meta[3].rob_idx = 6'd22;
    cycle(4'b1101, 1'b0, 1'b0);
    fu_meta[0].rob_idx = 6'd23;
    cycle(4'b0001, 1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      fu_meta[1].rob_idx = 6'(30 + p);
      cycle(4'b0010, 1'b0, 1'b0);
      n_chk++; if (fu_full[1] !== (p >= 1)) $display("FAIL fill_full p=%0d got=%b exp=%b", p, fu_full[1], p >= 1); else n_pass++;
      n_chk++; if (overflow !== (p == 2)) $display("FAIL fill_overflow p=%0d got=%b exp=%b", p, overflow, p == 2); else n_pass++;
    end
    for (int p = 0; p < 2; p++) begin
      cycle('0, 1'b0, 1'b0);
      n_chk++; if (cdb_valid !== 1'b1 || cdb_fu_idx !== 2'd1 || cdb_entry.rob_idx !== 6'(30 + p))
        $display("FAIL fill_drain p=%0d got v=%b idx=%0d rob=%0d exp v=1 idx=1 rob=%0d",
                 p, cdb_valid, cdb_fu_idx, cdb_entry.rob_idx, 30 + p);
      else n_pass++;
    end
    cycle('0, 1'b0, 1'b0);
    n_chk++; if (cdb_valid !== 1'b0) $display("FAIL fill_dropped got=%b exp=0", cdb_valid); else n_pass++;
  endtask

  task automatic test_flush();
    rand_meta();
    cycle(4'b0111, 1'b0, 1'b0);
    cycle(4'b1000, 1'b1, 1'b0);
    n_chk++; if (cdb_valid !== 1'b0) $display("FAIL flush_valid got=%b exp=0", cdb_valid); else n_pass++;
    n_chk++; if (fu_full !== '0) $display("FAIL flush_full got=%b exp=0", fu_full); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      cycle('0, 1'b0, 1'b0);
      n_chk++; if (cdb_valid !== 1'b0) $display("FAIL flush_leak c=%0d got=%b exp=0", c, cdb_valid); else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    rand_meta();
    cycle(4'b1001, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b1);
    n_chk++; if ({cdb_valid, cdb_fu_idx, cdb_entry, overflow, fu_full} !== '0)
      $display("FAIL midreset_outputs got v=%b idx=%0d e=%h ovf=%b full=%b exp all 0",
               cdb_valid, cdb_fu_idx, cdb_entry, overflow, fu_full);
    else n_pass++;
    fu_meta = '0;
    fu_meta[1].rob_idx = 6'd60;
    cycle(4'b0010, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    n_chk++; if (cdb_valid !== 1'b1 || cdb_fu_idx !== 2'd1 || cdb_entry.rob_idx !== 6'd60)
      $display("FAIL midreset_after got v=%b idx=%0d rob=%0d exp v=1 idx=1 rob=60",
               cdb_valid, cdb_fu_idx, cdb_entry.rob_idx);
    else n_pass++;
    cycle('0, 1'b0, 1'b0);
    n_chk++; if (cdb_valid !== 1'b0) $display("FAIL midreset_stale got=%b exp=0", cdb_valid); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      logic [N-1:0] d;
      for (int i = 0; i < N; i++) d[i] = ($urandom_range(0, 9) < 3);
      rand_meta();
      cycle(d, $urandom_range(0, 24) == 0, $urandom_range(0, 99) == 0);
      n_chk++; if (cdb_valid !== ev) $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, cdb_valid, ev); else n_pass++;
      n_chk++; if (cdb_entry !== ee) $display("FAIL rnd_entry c=%0d got=%h exp=%h", c, cdb_entry, ee); else n_pass++;
      n_chk++; if (cdb_fu_idx !== IW'(ei)) $display("FAIL rnd_idx c=%0d got=%0d exp=%0d", c, cdb_fu_idx, ei); else n_pass++;
      n_chk++; if (fu_full !== efull) $display("FAIL rnd_full c=%0d got=%b exp=%b", c, fu_full, efull); else n_pass++;
      n_chk++; if (overflow !== eovf) $display("FAIL rnd_overflow c=%0d got=%b exp=%b", c, overflow, eovf); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; fu_done = '0; fu_meta = '0;
    test_reset();
    test_single_op();
    test_contention();
    test_fill();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
